// File: rtl/password_lock_pkg.sv
// Shared definitions for the password lock: state encoding, 7-segment constants
// and the BCD digit to segment lookup.
package password_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_e;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_UNDER = 7'h08;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-BCD codes decode to blank.
module bcd_to_7seg
    import password_lock_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = digit_to_seg(i_digit);

endmodule

// File: rtl/password_lock.sv
// Clocked keypad password lock with retry lockout and per-digit 7-segment display.
// Build option: define PASSWORD_LOCK_MASK_EN to show entered digits as underscores.
module password_lock
    import password_lock_pkg::*;
#(
    parameter int N_DIGITS       = 3,
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 1000,
    parameter int LOCKOUT_CYCLES = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_key_valid,
    input  logic [3:0]              i_key_digit,
    input  logic                    i_key_enter,
    input  logic                    i_key_clear,
    input  logic [4*N_DIGITS-1:0]   i_password,
    output logic [7*N_DIGITS-1:0]   o_7seg,
    output logic                    o_unlock,
    output logic                    o_error,
    output logic                    o_lockout,
    output logic [3:0]              o_fail_cnt
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int TMR_W = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

`ifdef PASSWORD_LOCK_MASK_EN
    localparam bit MASK_DIGITS = 1'b1;
`else
    localparam bit MASK_DIGITS = 1'b0;
`endif

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [4*N_DIGITS-1:0]   r_buf;
    logic [4*N_DIGITS-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [TMR_W-1:0]        r_timer;
    logic [TMR_W-1:0]        w_timer_nxt;
    logic [3:0]              r_fail_cnt;
    logic [3:0]              w_fail_nxt;
    logic                    w_error_nxt;
    logic                    r_unlock;
    logic                    r_error;
    logic                    r_lockout;
    logic [7*N_DIGITS-1:0]   r_seg;
    logic [7*N_DIGITS-1:0]   w_seg_nxt;

    logic w_full;
    logic w_match;
    logic w_digit_ok;

    assign w_full     = (r_count == CNT_W'(N_DIGITS));
    assign w_match    = w_full && (r_buf == i_password);
    assign w_digit_ok = i_key_valid && (i_key_digit <= 4'd9);

    // Lockout is checked before i_en so toggling the enable cannot cut it short.
    always_comb begin
        // NOTE: every next-state signal takes a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_count_nxt = r_count;
        w_timer_nxt = r_timer;
        w_fail_nxt  = r_fail_cnt;
        w_error_nxt = 1'b0;
        if (r_state == ST_LOCKOUT) begin
            if (r_timer == '0) begin
                w_state_nxt = ST_IDLE;
                w_fail_nxt  = '0;
            end else begin
                w_timer_nxt = r_timer - TMR_W'(1);
            end
        end else if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_buf_nxt   = '0;
            w_count_nxt = '0;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    if (i_key_clear) begin
                        w_state_nxt = ST_IDLE;
                        w_buf_nxt   = '0;
                        w_count_nxt = '0;
                    end else if (i_key_enter) begin
                        w_state_nxt = ST_CHECK;
                    end else if (w_digit_ok && !w_full) begin
                        w_buf_nxt       = r_buf << 4;
                        w_buf_nxt[3:0]  = i_key_digit;
                        w_count_nxt     = r_count + CNT_W'(1);
                        w_state_nxt     = ST_ENTRY;
                    end
                end
                ST_CHECK: begin
                    w_buf_nxt   = '0;
                    w_count_nxt = '0;
                    if (w_match) begin
                        w_fail_nxt  = '0;
                        w_state_nxt = ST_UNLOCKED;
                        w_timer_nxt = TMR_W'(UNLOCK_CYCLES - 1);
                    end else begin
                        w_error_nxt = 1'b1;
                        w_fail_nxt  = r_fail_cnt + 4'd1;
                        if (r_fail_cnt + 4'd1 == 4'(MAX_TRIES)) begin
                            w_state_nxt = ST_LOCKOUT;
                            w_timer_nxt = TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (i_key_clear || r_timer == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Display is derived from the next state so it lands on the same edge as the buffer.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_pos
        logic [6:0] w_dec;

        bcd_to_7seg u_dec (
            .i_digit (w_buf_nxt[4*k +: 4]),
            .o_seg   (w_dec)
        );

        assign w_seg_nxt[7*k +: 7] =
            !i_en                        ? SEG_BLANK :
            (w_state_nxt == ST_LOCKOUT)  ? SEG_DASH  :
            (w_state_nxt == ST_UNLOCKED) ? SEG_ZERO  :
            (CNT_W'(k) < w_count_nxt)    ? (MASK_DIGITS ? SEG_UNDER : w_dec) :
                                           SEG_DASH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_count    <= '0;
            r_timer    <= '0;
            r_fail_cnt <= '0;
            r_unlock   <= 1'b0;
            r_error    <= 1'b0;
            r_lockout  <= 1'b0;
            r_seg      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_count    <= w_count_nxt;
            r_timer    <= w_timer_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_unlock   <= (w_state_nxt == ST_UNLOCKED);
            r_error    <= w_error_nxt;
            r_lockout  <= (w_state_nxt == ST_LOCKOUT);
            r_seg      <= w_seg_nxt;
        end
    end

    assign o_7seg     = r_seg;
    assign o_unlock   = r_unlock;
    assign o_error    = r_error;
    assign o_lockout  = r_lockout;
    assign o_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_password_lock.sv
// Bench for password_lock: table-driven opening sequence, hand-written corner cases
// and randomized keypad traffic, all checked against a queue-based reference model.
module tb_password_lock;

    localparam int N     = 3;
    localparam int TRIES = 3;
    localparam int UNL   = 4;
    localparam int LCK   = 8;
    localparam logic [11:0] PASSWORD = 12'h666;

    localparam logic [6:0] D6 = 7'h7D;
    localparam logic [6:0] DA = 7'h40;
    localparam logic [6:0] Z0 = 7'h3F;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b1;
    logic        i_key_valid = 1'b0;
    logic [3:0]  i_key_digit = 4'd0;
    logic        i_key_enter = 1'b0;
    logic        i_key_clear = 1'b0;
    logic [11:0] i_password = PASSWORD;
    logic [20:0] o_7seg;
    logic        o_unlock;
    logic        o_error;
    logic        o_lockout;
    logic [3:0]  o_fail_cnt;

    password_lock #(
        .N_DIGITS       (N),
        .MAX_TRIES      (TRIES),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_key_valid (i_key_valid),
        .i_key_digit (i_key_digit),
        .i_key_enter (i_key_enter),
        .i_key_clear (i_key_clear),
        .i_password  (i_password),
        .o_7seg      (o_7seg),
        .o_unlock    (o_unlock),
        .o_error     (o_error),
        .o_lockout   (o_lockout),
        .o_fail_cnt  (o_fail_cnt)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int n_err = 0;
    int n_lock = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: entered digits kept as a queue (oldest first), phases as
    // remaining-cycle counters.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int  q[$];
    int  unlock_left, lock_left, fails;
    bit  pending, m_err;
    logic [20:0] m_seg;

    function automatic int q_value();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    function automatic logic [20:0] m_disp(input bit en);
        logic [20:0] s = '0;
        for (int k = 0; k < N; k++) begin
            logic [6:0] p;
            if (!en)                 p = 7'h00;
            else if (lock_left > 0)  p = DA;
            else if (unlock_left > 0) p = Z0;
            else if (k < q.size())   p = seg_tab[q[q.size() - 1 - k]];
            else                     p = DA;
            s[7*k +: 7] = p;
        end
        return s;
    endfunction

    task automatic m_reset();
        q.delete();
        unlock_left = 0; lock_left = 0; fails = 0;
        pending = 0; m_err = 0; m_seg = '0;
    endtask

    task automatic m_step(input bit v, input int d, input bit ent, input bit clr, input bit en);
        m_err = 0;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (!en) begin
            q.delete(); pending = 0; unlock_left = 0;
        end else if (pending) begin
            pending = 0;
            if (q.size() == N && q_value() == int'(PASSWORD)) begin
                fails = 0;
                unlock_left = UNL;
            end else begin
                m_err = 1;
                fails++;
                if (fails == TRIES) lock_left = LCK;
            end
            q.delete();
        end else if (unlock_left > 0) begin
            if (clr) unlock_left = 0;
            else     unlock_left--;
        end else if (clr) begin
            q.delete();
        end else if (ent) begin
            pending = 1;
        end else if (v && d <= 9 && q.size() < N) begin
            q.push_back(d);
        end
        m_seg = m_disp(en);
    endtask

    // One clock: drive inputs, let the edge happen, then compare against the model.
    task automatic step(input bit v, input logic [3:0] d, input bit ent, input bit clr, input bit en);
        i_key_valid = v; i_key_digit = d; i_key_enter = ent; i_key_clear = clr; i_en = en;
        @(posedge i_clk);
        m_step(v, int'(d), ent, clr, en);
        #1;
        check("unlock",   32'(o_unlock),   32'(unlock_left > 0));
        check("error",    32'(o_error),    32'(m_err));
        check("lockout",  32'(o_lockout),  32'(lock_left > 0));
        check("fail_cnt", 32'(o_fail_cnt), 32'(fails));
        check("7seg",     32'(o_7seg),     32'(m_seg));
        if (o_error)   n_err++;
        if (o_lockout) n_lock++;
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic enter();
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic wrong_attempt();
        key(4'd1); key(4'd2); key(4'd3); enter(); idle();
    endtask

    // Asynchronous reset applied between clock edges; outputs must drop at once.
    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_unlock",  32'(o_unlock),   32'd0);
        check("rst_error",   32'(o_error),    32'd0);
        check("rst_lockout", 32'(o_lockout),  32'd0);
        check("rst_fail",    32'(o_fail_cnt), 32'd0);
        check("rst_7seg",    32'(o_7seg),     32'd0);
        m_reset();
        i_key_valid = 0; i_key_enter = 0; i_key_clear = 0; i_en = 1;
        #3 i_rst_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        logic [3:0]  d;
        bit          ent;
        bit          clr;
        bit          x_unlock;
        bit          x_error;
        bit          x_lockout;
        logic [3:0]  x_fail;
        logic [20:0] x_seg;
    } vec_t;

    function automatic vec_t mk(input bit v, input logic [3:0] d, input bit ent, input bit clr,
                                input bit un, input bit er, input bit lk,
                                input logic [3:0] fc, input logic [20:0] sg);
        vec_t r;
        r.v = v; r.d = d; r.ent = ent; r.clr = clr;
        r.x_unlock = un; r.x_error = er; r.x_lockout = lk; r.x_fail = fc; r.x_seg = sg;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        tbl[0] = mk(1, 6, 0, 0, 0, 0, 0, 0, {DA, DA, D6});
        tbl[1] = mk(1, 6, 0, 0, 0, 0, 0, 0, {DA, D6, D6});
        tbl[2] = mk(1, 6, 0, 0, 0, 0, 0, 0, {D6, D6, D6});
        tbl[3] = mk(0, 0, 1, 0, 0, 0, 0, 0, {D6, D6, D6});
        tbl[4] = mk(0, 0, 0, 0, 1, 0, 0, 0, {Z0, Z0, Z0});
        tbl[5] = mk(0, 0, 0, 0, 1, 0, 0, 0, {Z0, Z0, Z0});
        tbl[6] = mk(0, 0, 0, 0, 1, 0, 0, 0, {Z0, Z0, Z0});
        tbl[7] = mk(0, 0, 0, 0, 1, 0, 0, 0, {Z0, Z0, Z0});
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, {DA, DA, DA});

        m_reset();
        #6;
        do_reset();
        idle();

        // Correct code opens the lock two cycles after enter, for UNL cycles.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].ent, tbl[i].clr, 1'b1);
            check($sformatf("tbl%0d_unlock", i),  32'(o_unlock),   32'(tbl[i].x_unlock));
            check($sformatf("tbl%0d_error", i),   32'(o_error),    32'(tbl[i].x_error));
            check($sformatf("tbl%0d_lockout", i), 32'(o_lockout),  32'(tbl[i].x_lockout));
            check($sformatf("tbl%0d_fail", i),    32'(o_fail_cnt), 32'(tbl[i].x_fail));
            check($sformatf("tbl%0d_7seg", i),    32'(o_7seg),     32'(tbl[i].x_seg));
        end

        // Three failures lock the keypad; keys during lockout are ignored.
        n_err = 0; n_lock = 0;
        wrong_attempt();
        wrong_attempt();
        wrong_attempt();
        check("lock_fail_cnt", 32'(o_fail_cnt), 32'd3);
        check("lock_7seg",     32'(o_7seg),     32'({DA, DA, DA}));
        key(4'd6); key(4'd6); key(4'd6); enter();
        for (int i = 0; i < 8; i++) idle();
        check("lock_err_pulses", 32'(n_err),  32'd3);
        check("lock_cycles",     32'(n_lock), 32'(LCK));
        check("lock_fail_after", 32'(o_fail_cnt), 32'd0);
        check("lock_no_unlock",  32'(o_unlock),   32'd0);

        // Short entry fails; an overlong entry keeps the first N digits.
        key(4'd6); key(4'd6); enter(); idle();
        check("short_error", 32'(o_error),    32'd1);
        check("short_fail",  32'(o_fail_cnt), 32'd1);
        key(4'd6); key(4'd6); key(4'd6); key(4'd6);
        check("overlong_7seg", 32'(o_7seg), 32'({D6, D6, D6}));
        enter(); idle();
        check("overlong_unlock", 32'(o_unlock),   32'd1);
        check("overlong_fail",   32'(o_fail_cnt), 32'd0);
        for (int i = 0; i < 4; i++) idle();

        // Same-cycle strobes: enter beats the digit, clear beats the digit.
        step(1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
        idle();
        check("key_enter_error", 32'(o_error), 32'd1);
        step(1'b1, 4'd6, 1'b0, 1'b1, 1'b1);
        check("key_clear_7seg", 32'(o_7seg), 32'({DA, DA, DA}));

        // Non-BCD key ignored; dropping i_en blanks and clears the entry.
        key(4'd6);
        key(4'hA);
        check("nonbcd_7seg", 32'(o_7seg), 32'({DA, DA, D6}));
        key(4'd6);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("en_off_7seg", 32'(o_7seg), 32'd0);
        idle();
        check("en_on_7seg", 32'(o_7seg), 32'({DA, DA, DA}));

        // Toggling i_en cannot shorten a lockout.
        do_reset();
        n_err = 0; n_lock = 0;
        wrong_attempt();
        wrong_attempt();
        wrong_attempt();
        for (int i = 0; i < 12; i++) step(1'b0, 4'd0, 1'b0, 1'b0, (i % 2) == 1);
        check("en_toggle_lock_cycles", 32'(n_lock), 32'(LCK));
        check("en_toggle_fail_after",  32'(o_fail_cnt), 32'd0);

        // Asynchronous reset while unlocked.
        idle();
        key(4'd6); key(4'd6); key(4'd6); enter(); idle();
        check("pre_reset_unlock", 32'(o_unlock), 32'd1);
        do_reset();

        // Randomized keypad traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit v, e, c, en;
            logic [3:0] d;
            en = ($urandom_range(0, 29) != 0);
            c  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 5) == 0);
            v  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 9) < 7) ? 4'd6 : 4'($urandom_range(0, 15));
            step(v, d, e, c, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
